// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: NPC op codes and FSM states.
package pc_fetch_ctrl_pkg;

  // Next-PC unit op codes, shared with the external NPC unit.
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RIG    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PRESENT,
    S_HALT
  } fetch_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the architectural PC, issues one imem request at a
// time, presents the fetched word to decode and loads the next PC from the
// external NPC unit when decode consumes the instruction.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fetch_en,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  input  logic             instr_ready,
  input  logic             redir_valid,
  input  logic [1:0]       redir_op,
  output logic [31:0]      npc_pc,
  output logic [1:0]       npc_op,
  input  logic [31:0]      npc_in,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             consume;
  logic             pc_load;
  logic             err_set;
  logic             instr_load;

  // Next-state, NPC op selection and register-update strobes.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    instr_valid = 1'b0;
    npc_op     = NPC_PLUS4;
    consume    = 1'b0;
    pc_load    = 1'b0;
    err_set    = 1'b0;
    instr_load = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (fetch_en) state_d = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        // A grant in the same cycle as fetch_en dropping still commits the fetch.
        if (imem_gnt)       state_d = S_WAIT;
        else if (!fetch_en) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_load = 1'b1;
          state_d    = S_PRESENT;
        end
      end
      S_PRESENT: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          consume = 1'b1;
          if (redir_valid) npc_op = redir_op;
          if (is_misaligned(npc_in)) begin
            err_set = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_load = 1'b1;
            state_d = fetch_en ? S_REQ : S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC, instruction, error flag and retire counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_load)    pc_q    <= npc_in;
      if (instr_load) instr_q <= imem_rdata;
      if (err_set)    err_q   <= 1'b1;
      if (consume)    cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = pc_q;
  assign npc_pc       = pc_q;
  assign misalign_err = err_q;
  assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by a
// randomized run, checked against a transaction-level model of PC/count/error.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redir_valid;
  logic [1:0]  redir_op;
  logic [31:0] npc_pc;
  logic [1:0]  npc_op;
  logic [31:0] npc_in;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  // Operands of the stand-in NPC unit.
  logic [15:0] br_off;
  logic [25:0] j_idx;
  logic [31:0] rsv;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  // Model state.
  logic [31:0] exp_pc;
  int          exp_cnt;
  logic        exp_err;
  logic        halted;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redir_valid(redir_valid), .redir_op(redir_op),
    .npc_pc(npc_pc), .npc_op(npc_op), .npc_in(npc_in),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] op);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    case (op)
      NPC_BRANCH: return p4 + {{14{br_off[15]}}, br_off, 2'b00};
      NPC_JUMP:   return {p4[31:28], j_idx, 2'b00};
      NPC_RIG:    return rsv;
      default:    return p4;
    endcase
  endfunction

  // Combinational NPC unit as the parent would wire it.
  always_comb npc_in = ref_next(npc_pc, npc_op);

  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp = n_cmp + 1;
    assert (obs === expv) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full fetch transaction entered with the DUT in its request cycle.
  task automatic fetch_one(input int gd, input int rd, input int yd,
                           input logic redir, input logic [1:0] op, input logic drop_en);
    logic [31:0] word;
    logic [1:0]  eff;
    logic [31:0] nxt;
    int          t0;
    word = $urandom;
    t0   = cyc;
    check("req", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < gd; i++) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      step();
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("addr_stable", imem_addr, exp_pc);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("wait_noreq", {31'd0, imem_req}, 32'd0);
    if (drop_en) fetch_en = 1'b0;
    for (int i = 0; i < rd; i++) begin
      step();
      check("wait_novalid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check("present_valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, word);
    check("instr_pc", instr_pc, exp_pc);
    check("cnt_before", fetch_cnt, 32'(exp_cnt));
    for (int i = 0; i < yd; i++) begin
      instr_ready = 1'b0;
      redir_valid = 1'($urandom_range(0, 1));
      redir_op    = 2'($urandom);
      #1;
      check("npc_op_idle", {30'd0, npc_op}, {30'd0, NPC_PLUS4});
      step();
      check("instr_stable", instr, word);
      check("pc_stable", instr_pc, exp_pc);
      check("cnt_stable", fetch_cnt, 32'(exp_cnt));
    end
    instr_ready = 1'b1;
    redir_valid = redir;
    redir_op    = op;
    #1;
    eff = redir ? op : NPC_PLUS4;
    check("npc_op", {30'd0, npc_op}, {30'd0, eff});
    check("npc_pc", npc_pc, exp_pc);
    nxt = ref_next(exp_pc, eff);
    step();
    instr_ready = 1'b0;
    redir_valid = 1'b0;
    exp_cnt = exp_cnt + 1;
    if (nxt[1:0] != 2'b00) begin
      exp_err = 1'b1;
      halted  = 1'b1;
    end else begin
      exp_pc = nxt;
    end
    check("cnt_after", fetch_cnt, 32'(exp_cnt));
    check("misalign", {31'd0, misalign_err}, {31'd0, exp_err});
    check("pc_after", instr_pc, exp_pc);
    if (!halted && fetch_en) begin
      check("latency", 32'(cyc - t0), 32'(3 + gd + rd + yd));
      check("next_req", {31'd0, imem_req}, 32'd1);
      check("next_addr", imem_addr, exp_pc);
    end else begin
      check("stopped", {31'd0, imem_req}, 32'd0);
    end
  endtask

  initial begin
    logic [1:0] rop;
    logic       rdir;
    logic       rdrop;
    rstn = 1'b0; fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0; redir_valid = 1'b0; redir_op = NPC_PLUS4;
    br_off = '0; j_idx = '0; rsv = '0;
    exp_pc = 32'h0000_3000; exp_cnt = 0; exp_err = 1'b0; halted = 1'b0;
    step(); step();

    // Reset state
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'h0000_3000);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_err", {31'd0, misalign_err}, 32'd0);
    check("rst_npc_op", {30'd0, npc_op}, {30'd0, NPC_PLUS4});

    rstn = 1'b1;
    fetch_en = 1'b1;
    step();

    // Back-to-back sequential fetches at best-case latency
    for (int i = 0; i < 3; i++) fetch_one(0, 0, 0, 1'b0, NPC_PLUS4, 1'b0);
    check("t1_cnt", fetch_cnt, 32'd3);
    check("t1_addr", imem_addr, 32'h0000_300C);

    // Jump redirect
    j_idx = 26'h0000C10;
    fetch_one(0, 0, 0, 1'b1, NPC_JUMP, 1'b0);
    check("t2_addr", imem_addr, 32'h0000_3040);
    check("t2_cnt", fetch_cnt, 32'd4);

    // Grant and ready stalls
    fetch_one(4, 0, 3, 1'b0, NPC_PLUS4, 1'b0);

    // Withdraw the request before grant, then resume at the same PC
    fetch_en = 1'b0;
    step();
    check("t6_req_drop", {31'd0, imem_req}, 32'd0);
    step();
    check("t6_idle", {31'd0, imem_req}, 32'd0);
    fetch_en = 1'b1;
    step();
    check("t6_req_again", {31'd0, imem_req}, 32'd1);
    check("t6_addr", imem_addr, exp_pc);

    // Stop requested after grant: fetch completes, then idle
    fetch_one(1, 1, 1, 1'b0, NPC_PLUS4, 1'b1);
    fetch_en = 1'b1;
    step();

    // Randomized run with aligned redirect targets
    for (int n = 0; n < 40; n++) begin
      br_off = 16'($urandom);
      j_idx  = 26'($urandom);
      rsv    = $urandom & 32'hFFFF_FFFC;
      rop    = 2'($urandom);
      rdir   = ($urandom_range(0, 3) == 0);
      rdrop  = ($urandom_range(0, 7) == 0);
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                rdir, rop, rdrop);
      if (rdrop) begin
        fetch_en = 1'b1;
        step();
      end
    end

    // Reset while waiting for read data; stale rvalid afterwards is ignored
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    fetch_en = 1'b0;
    rstn = 1'b0;
    #1;
    check("t5_async_req", {31'd0, imem_req}, 32'd0);
    check("t5_async_cnt", fetch_cnt, 32'd0);
    check("t5_async_pc", instr_pc, 32'h0000_3000);
    step();
    rstn = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    check("t5_stale_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_stale_instr", instr, 32'd0);
    check("t5_stale_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b0;
    fetch_en = 1'b1;
    exp_pc = 32'h0000_3000; exp_cnt = 0; exp_err = 1'b0;
    step();
    check("t5_first_addr", imem_addr, 32'h0000_3000);
    fetch_one(0, 1, 0, 1'b0, NPC_PLUS4, 1'b0);

    // Misaligned register target halts the sequencer
    rsv = 32'h0000_3002;
    fetch_one(0, 0, 0, 1'b1, NPC_RIG, 1'b0);
    check("t4_err", {31'd0, misalign_err}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_gnt    = 1'b1;
      instr_ready = 1'b1;
      step();
      check("t4_halt_req", {31'd0, imem_req}, 32'd0);
      check("t4_halt_valid", {31'd0, instr_valid}, 32'd0);
      check("t4_halt_pc", instr_pc, exp_pc);
      check("t4_halt_cnt", fetch_cnt, 32'(exp_cnt));
      check("t4_halt_err", {31'd0, misalign_err}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
